// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache metadata table and its flush sequencer.
package cache_pkg;

    localparam int IDX_W_DEF = 8;
    localparam int TAG_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        EVICT = 2'd2,
        DONE  = 2'd3
    } flush_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_W_DEF-1:0] tag;
    } meta_entry_t;

endpackage

// File: rtl/cache_meta_table_if.sv
// Request, lookup-result, flush-control and write-back handshake bundle of the metadata table.
interface cache_meta_table_if
    import cache_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int TAG_W = TAG_W_DEF
);
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             rd_hit;
    logic             rd_dirty;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_dirty;
    logic             flush_req;
    logic             busy;
    logic             flush_done;
    logic             evict_valid;
    logic             evict_ready;
    logic [IDX_W-1:0] evict_idx;
    logic [TAG_W-1:0] evict_tag;

    modport master (
        output rd_en, rd_idx, rd_tag, wr_en, wr_idx, wr_tag, wr_dirty, flush_req, evict_ready,
        input  rd_valid, rd_hit, rd_dirty, busy, flush_done, evict_valid, evict_idx, evict_tag
    );

    modport slave (
        input  rd_en, rd_idx, rd_tag, wr_en, wr_idx, wr_tag, wr_dirty, flush_req, evict_ready,
        output rd_valid, rd_hit, rd_dirty, busy, flush_done, evict_valid, evict_idx, evict_tag
    );
endinterface

// File: rtl/cache_flush_fsm.sv
// Flush sequencer: walks every line, offers dirty lines for write-back and
// issues a registered clear strobe for each line it has finished with.
module cache_flush_fsm
    import cache_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush_req,
    input  logic             i_line_valid,
    input  logic             i_line_dirty,
    input  logic [TAG_W-1:0] i_line_tag,
    input  logic             i_evict_ready,
    output logic [IDX_W-1:0] o_ptr,
    output logic             o_busy,
    output logic             o_flush_done,
    output logic             o_evict_valid,
    output logic [IDX_W-1:0] o_evict_idx,
    output logic [TAG_W-1:0] o_evict_tag,
    output logic             o_clr_en,
    output logic [IDX_W-1:0] o_clr_idx
);
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    flush_state_e     r_state;
    logic [IDX_W-1:0] r_ptr;
    logic             r_busy;
    logic             r_done;
    logic             r_evict_valid;
    logic [IDX_W-1:0] r_evict_idx;
    logic [TAG_W-1:0] r_evict_tag;
    logic             r_clr_en;
    logic [IDX_W-1:0] r_clr_idx;

    // Flush state machine; the clear lands one edge after a line is retired, while still busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_evict_valid <= 1'b0;
            r_evict_idx   <= '0;
            r_evict_tag   <= '0;
            r_clr_en      <= 1'b0;
            r_clr_idx     <= '0;
        end else begin
            r_done   <= 1'b0;
            r_clr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_flush_req) begin
                        r_state <= SCAN;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (i_line_valid && i_line_dirty) begin
                        r_state       <= EVICT;
                        r_evict_valid <= 1'b1;
                        r_evict_idx   <= r_ptr;
                        r_evict_tag   <= i_line_tag;
                    end else begin
                        r_clr_en  <= 1'b1;
                        r_clr_idx <= r_ptr;
                        if (r_ptr == LAST_IDX) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + IDX_W'(1);
                        end
                    end
                end
                EVICT: begin
                    if (i_evict_ready) begin
                        r_evict_valid <= 1'b0;
                        r_clr_en      <= 1'b1;
                        r_clr_idx     <= r_ptr;
                        if (r_ptr == LAST_IDX) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ptr   <= r_ptr + IDX_W'(1);
                            r_state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state       <= IDLE;
                    r_busy        <= 1'b0;
                    r_evict_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ptr         = r_ptr;
    assign o_busy        = r_busy;
    assign o_flush_done  = r_done;
    assign o_evict_valid = r_evict_valid;
    assign o_evict_idx   = r_evict_idx;
    assign o_evict_tag   = r_evict_tag;
    assign o_clr_en      = r_clr_en;
    assign o_clr_idx     = r_clr_idx;
endmodule

// File: rtl/cache_meta_table.sv
// Per-line valid/dirty/tag store with registered lookup, single-port write and
// a sequenced flush that hands dirty lines to the write-back path.
module cache_meta_table
    import cache_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    cache_meta_table_if.slave bus
);
    localparam int DEPTH = 2**IDX_W;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_dirty;
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic             r_rd_valid;
    logic             r_rd_hit;
    logic             r_rd_dirty;

    logic             w_busy;
    logic             w_accept;
    logic             w_rd_go;
    logic             w_wr_go;
    logic             w_lookup_hit;
    logic             w_clr_en;
    logic [IDX_W-1:0] w_clr_idx;
    logic [IDX_W-1:0] w_ptr;

    // A flush request wins over host traffic in the same cycle
    assign w_accept     = !w_busy && !bus.flush_req;
    assign w_rd_go      = bus.rd_en && w_accept;
    assign w_wr_go      = bus.wr_en && w_accept;
    assign w_lookup_hit = r_valid[bus.rd_idx] && (r_tag[bus.rd_idx] == bus.rd_tag);

    // Valid/dirty flags: host writes while idle, flush clears while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_wr_go) begin
            r_valid[bus.wr_idx] <= 1'b1;
            r_dirty[bus.wr_idx] <= bus.wr_dirty;
        end else if (w_clr_en) begin
            r_valid[w_clr_idx] <= 1'b0;
            r_dirty[w_clr_idx] <= 1'b0;
        end
    end

    // Tag storage; meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            r_tag[bus.wr_idx] <= bus.wr_tag;
        end
    end

    // Registered lookup, sampling contents before any same-edge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_dirty <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_go;
            r_rd_hit   <= w_rd_go && w_lookup_hit;
            r_rd_dirty <= w_rd_go && w_lookup_hit && r_dirty[bus.rd_idx];
        end
    end

    cache_flush_fsm #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_flush_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush_req   (bus.flush_req),
        .i_line_valid  (r_valid[w_ptr]),
        .i_line_dirty  (r_dirty[w_ptr]),
        .i_line_tag    (r_tag[w_ptr]),
        .i_evict_ready (bus.evict_ready),
        .o_ptr         (w_ptr),
        .o_busy        (w_busy),
        .o_flush_done  (bus.flush_done),
        .o_evict_valid (bus.evict_valid),
        .o_evict_idx   (bus.evict_idx),
        .o_evict_tag   (bus.evict_tag),
        .o_clr_en      (w_clr_en),
        .o_clr_idx     (w_clr_idx)
    );

    assign bus.busy     = w_busy;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_hit   = r_rd_hit;
    assign bus.rd_dirty = r_rd_dirty;
endmodule

// File: tb/tb_cache_meta_table.sv
// Randomised bench for cache_meta_table against an array-of-lines reference model.
module tb_cache_meta_table;
    import cache_pkg::*;

    localparam int IDX_W = 8;
    localparam int TAG_W = 20;
    localparam int DEPTH = 256;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   busy_len;

    meta_entry_t mdl [DEPTH];

    cache_meta_table_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

    cache_meta_table #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_en = 1'b0; bus.rd_idx = '0; bus.rd_tag = '0;
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_tag = '0; bus.wr_dirty = 1'b0;
        bus.flush_req = 1'b0; bus.evict_ready = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i].valid = 1'b0;
            mdl[i].dirty = 1'b0;
        end
    endtask

    // One idle-state cycle: optional lookup and optional write, checked against the model
    task automatic op(input bit re, input int ri, input int rt,
                      input bit we, input int wi, input int wt, input bit wd);
        bit eh;
        bit ed;
        bus.rd_en = re; bus.rd_idx = ri[IDX_W-1:0]; bus.rd_tag = rt[TAG_W-1:0];
        bus.wr_en = we; bus.wr_idx = wi[IDX_W-1:0]; bus.wr_tag = wt[TAG_W-1:0]; bus.wr_dirty = wd;
        eh = re && mdl[ri].valid && (mdl[ri].tag == rt[TAG_W-1:0]);
        ed = eh && mdl[ri].dirty;
        step();
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        check_val("rd_valid", bus.rd_valid, re);
        check_val("rd_hit", bus.rd_hit, eh);
        check_val("rd_dirty", bus.rd_dirty, ed);
        check_val("busy_idle", bus.busy, 1'b0);
        check_val("done_idle", bus.flush_done, 1'b0);
        if (we) begin
            mdl[wi].valid = 1'b1;
            mdl[wi].dirty = wd;
            mdl[wi].tag   = wt[TAG_W-1:0];
        end
    endtask

    // Full flush with scoreboarded evictions; the first offer is refused for 'stall' cycles
    task automatic run_flush(input int stall, input bit noise, output int busy_cyc);
        int q_idx[$];
        int ev_cyc;
        int done_cnt;
        int wait_cnt;
        bit first;
        bit rdy;
        logic [IDX_W-1:0] held_idx;
        logic [TAG_W-1:0] held_tag;
        for (int i = 0; i < DEPTH; i++)
            if (mdl[i].valid && mdl[i].dirty) q_idx.push_back(i);
        busy_cyc = 0; ev_cyc = 0; done_cnt = 0; wait_cnt = 0; first = 1'b1;
        held_idx = '0; held_tag = '0;
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        check_val("busy_start", bus.busy, 1'b1);
        for (int c = 0; c < 4000; c++) begin
            if (!bus.busy) break;
            busy_cyc++;
            if (bus.flush_done) done_cnt++;
            check_val("rd_valid_busy", bus.rd_valid, 1'b0);
            if (bus.evict_valid) begin
                ev_cyc++;
                if (wait_cnt == 0) begin
                    if (q_idx.size() == 0) begin
                        check_val("evict_extra", 32'd1, 32'd0);
                    end else begin
                        check_val("evict_idx", bus.evict_idx, q_idx[0]);
                        check_val("evict_tag", bus.evict_tag, mdl[q_idx[0]].tag);
                    end
                    held_idx = bus.evict_idx;
                    held_tag = bus.evict_tag;
                end else begin
                    check_val("evict_hold_idx", bus.evict_idx, held_idx);
                    check_val("evict_hold_tag", bus.evict_tag, held_tag);
                end
                rdy = (first && wait_cnt < stall) ? 1'b0 : 1'($urandom_range(0, 1));
                bus.evict_ready = rdy;
                if (rdy) begin
                    if (q_idx.size() != 0) void'(q_idx.pop_front());
                    wait_cnt = 0;
                    first = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus.evict_ready = 1'($urandom_range(0, 1));
            end
            if (noise) begin
                bus.rd_en = 1'($urandom_range(0, 1));
                bus.rd_idx = IDX_W'($urandom_range(0, DEPTH - 1));
                bus.rd_tag = TAG_W'($urandom_range(0, 3));
                bus.wr_en = 1'($urandom_range(0, 1));
                bus.wr_idx = IDX_W'($urandom_range(0, DEPTH - 1));
                bus.wr_tag = TAG_W'($urandom_range(0, 3));
                bus.wr_dirty = 1'($urandom_range(0, 1));
                bus.flush_req = 1'($urandom_range(0, 1));
            end
            step();
        end
        check_val("flush_timeout", bus.busy, 1'b0);
        check_val("rd_valid_after", bus.rd_valid, 1'b0);
        check_val("done_after", bus.flush_done, 1'b0);
        idle_inputs();
        check_val("evict_left", q_idx.size(), 0);
        check_val("done_pulses", done_cnt, 1);
        check_val("busy_cycles", busy_cyc, DEPTH + 1 + ev_cyc);
        model_clear();
    endtask

    initial begin
        bit found;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("rst_rd_valid", bus.rd_valid, 1'b0);
        check_val("rst_rd_hit", bus.rd_hit, 1'b0);
        check_val("rst_rd_dirty", bus.rd_dirty, 1'b0);
        check_val("rst_busy", bus.busy, 1'b0);
        check_val("rst_done", bus.flush_done, 1'b0);
        check_val("rst_evict_valid", bus.evict_valid, 1'b0);

        op(1, 5, 'h12345, 0, 0, 0, 0);
        op(0, 0, 0, 1, 5, 'h12345, 1);
        op(1, 5, 'h12345, 0, 0, 0, 0);
        op(1, 5, 'h12346, 0, 0, 0, 0);
        op(1, 9, 'hA, 1, 9, 'hA, 0);
        op(1, 9, 'hA, 0, 0, 0, 0);

        // Directed flush: dirty 3 and 255, clean 7 and 9, line 5 rewritten clean
        op(0, 0, 0, 1, 5, 'h12345, 0);
        op(0, 0, 0, 1, 3, 'h3, 1);
        op(0, 0, 0, 1, 255, 'hFF, 1);
        op(0, 0, 0, 1, 7, 'h7, 0);
        run_flush(4, 0, busy_len);
        op(1, 3, 'h3, 0, 0, 0, 0);
        op(1, 7, 'h7, 0, 0, 0, 0);
        op(1, 255, 'hFF, 0, 0, 0, 0);

        // All-clean flush
        op(0, 0, 0, 1, 0, 'h1, 0);
        op(0, 0, 0, 1, 128, 'h2, 0);
        run_flush(0, 0, busy_len);
        check_val("allclean_busy", busy_len, 257);

        // Random traffic, then a flush with conflicting inputs
        for (int i = 0; i < 300; i++) begin
            op(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
        end
        run_flush(2, 1, busy_len);
        for (int i = 0; i < 40; i++) op(1, $urandom_range(0, 15), $urandom_range(0, 3), 0, 0, 0, 0);

        // Reset while a line is on offer
        op(0, 0, 0, 1, 20, 'h14, 1);
        op(0, 0, 0, 1, 40, 'h28, 1);
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (bus.evict_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_val("mid_offer_seen", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_evict", bus.evict_valid, 1'b0);
        check_val("mid_rst_busy", bus.busy, 1'b0);
        check_val("mid_rst_done", bus.flush_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        op(1, 20, 'h14, 0, 0, 0, 0);
        op(1, 40, 'h28, 0, 0, 0, 0);
        op(1, 5, 'h12345, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
